// File: rtl/dmem_access_unit.sv
// Load/store access unit between the memory stage and a byte-enabled data RAM.
// One request at a time: IDLE -> ACCESS (single RAM cycle) -> RESP, or IDLE -> RESP on error.
module dmem_access_unit #(
  parameter logic [31:0] BASE = 32'h1001_0000,
  parameter int unsigned SIZE = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_ena,
  output logic        dm_wena,
  output logic [3:0]  dm_byteEna,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held until that edge and its payload does not change.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        req_fire;
  logic [2:0]  req_nbytes;
  logic        misaligned;
  logic [31:0] req_off;
  logic [32:0] req_end;
  logic        out_of_range;
  logic        req_err;
  logic        store_q;
  logic [31:0] load_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign req_fire   = req_valid && req_ready;
  assign dbg_state  = state;

  // Error check on the request fields; they are latched unchanged on this same edge.
  always_comb begin
    req_nbytes = 3'd1;
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW: begin
        req_nbytes = 3'd4;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      OP_LH, OP_LHU, OP_SH: begin
        req_nbytes = 3'd2;
        misaligned = req_addr[0];
      end
      default: begin
        req_nbytes = 3'd1;
        misaligned = 1'b0;
      end
    endcase
    // 33-bit compare so an address below BASE wraps to a huge offset and fails.
    req_off      = req_addr - BASE;
    req_end      = {1'b0, req_off} + {30'b0, req_nbytes};
    out_of_range = (req_end > 33'(SIZE));
    req_err      = misaligned || out_of_range;
  end

  assign store_q = op_q[2] && (op_q[1] || op_q[0]);

  always_comb begin
    load_data = 32'h0;
    case (op_q)
      OP_LW:   load_data = dm_rdata;
      OP_LH:   load_data = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
      OP_LHU:  load_data = {16'h0, dm_rdata[15:0]};
      OP_LB:   load_data = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
      OP_LBU:  load_data = {24'h0, dm_rdata[7:0]};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        resp_err <= req_err;
        if (req_err) resp_rdata <= 32'h0;
      end
      if (state == ACCESS) begin
        resp_rdata <= load_data;
        resp_err   <= 1'b0;
      end
    end
  end

  // RAM strobes come from state only, so an async reset drops them at once.
  always_comb begin
    dm_ena     = 1'b0;
    dm_wena    = 1'b0;
    dm_byteEna = 4'b0000;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    if (state == ACCESS) begin
      dm_ena  = 1'b1;
      dm_wena = store_q;
      dm_addr = addr_q;
      if (store_q) dm_wdata = wdata_q;
      case (op_q)
        OP_LW, OP_SW:         dm_byteEna = 4'b1111;
        OP_LH, OP_LHU, OP_SH: dm_byteEna = 4'b0011;
        OP_LB, OP_LBU, OP_SB: dm_byteEna = 4'b0001;
        default:              dm_byteEna = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a byte-enabled RAM model and an
// expected-response queue checked as each response appears.
module tb_dmem_access_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_ena;
  logic        dm_wena;
  logic [3:0]  dm_byteEna;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  dmem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_ena(dm_ena), .dm_wena(dm_wena), .dm_byteEna(dm_byteEna),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // RAM model: write on rising edge, asynchronous read, byte at addr in [7:0].
  logic [7:0]  mem [0:511];
  logic [31:0] moff;
  assign moff = dm_addr - BASE;

  function automatic logic [8:0] midx(input logic [31:0] off, input int j);
    logic [31:0] s;
    s = off + 32'(j);
    return s[8:0];
  endfunction

  always @(posedge clk) begin
    if (dm_ena && dm_wena) begin
      for (int j = 0; j < 4; j++)
        if (dm_byteEna[j]) mem[midx(moff, j)] <= dm_wdata[8*j +: 8];
    end
  end

  assign dm_rdata = dm_ena ? {mem[midx(moff, 3)], mem[midx(moff, 2)],
                              mem[midx(moff, 1)], mem[midx(moff, 0)]} : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err);
    exp_q.push_back(rdata);
    exp_err_q.push_back(err);
  endtask

  // Drives one request and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the response, checks RAM strobes seen on the way, then completes
  // the handshake after `hold` stall cycles.
  task automatic collect(input string tag, input int exp_lat, input logic exp_ena,
                         input logic [3:0] exp_be, input logic exp_we,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                         input int hold);
    int lat;
    logic saw_ena;
    logic [3:0] be;
    logic we;
    logic [31:0] a, wd, er;
    logic ee;
    lat = 0; saw_ena = 1'b0; be = 4'h0; we = 1'b0; a = 32'h0; wd = 32'h0;
    do begin
      @(negedge clk);
      lat++;
      if (dm_ena) begin
        saw_ena = 1'b1; be = dm_byteEna; we = dm_wena; a = dm_addr; wd = dm_wdata;
      end
    end while (!resp_valid && lat < 10);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dm_ena_seen"}, {31'b0, saw_ena}, {31'b0, exp_ena});
    if (exp_ena) begin
      check({tag, "_byteEna"}, {28'b0, be}, {28'b0, exp_be});
      check({tag, "_wena"}, {31'b0, we}, {31'b0, exp_we});
      check({tag, "_dm_addr"}, a, exp_addr);
      check({tag, "_dm_wdata"}, wd, exp_wd);
    end
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'h1);
    er = 32'h0; ee = 1'b0;
    if (exp_q.size() > 0) begin
      er = exp_q.pop_front();
      ee = exp_err_q.pop_front();
    end
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_err"}, {31'b0, resp_err}, {31'b0, ee});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'h1);
      check({tag, "_hold_rdata"}, resp_rdata, er);
      check({tag, "_hold_req_ready"}, {31'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_dropped"}, {31'b0, resp_valid}, 32'h0);
    check({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_dm_ena", {31'b0, dm_ena}, 32'h0);
    check("rst_dm_wena", {31'b0, dm_wena}, 32'h0);
    check("rst_dm_byteEna", {28'b0, dm_byteEna}, 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    rst = 1'b0;

    // Word store and load back; valid rises after edge k+1
    expect_resp(32'h0, 1'b0);
    issue(OP_SW, 32'h1001_0010, 32'hDEAD_BEEF);
    collect("sw", 2, 1'b1, 4'b1111, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 0);
    expect_resp(32'hDEAD_BEEF, 1'b0);
    issue(OP_LW, 32'h1001_0010, 32'h5555_5555);
    collect("lw", 2, 1'b1, 4'b1111, 1'b0, 32'h1001_0010, 32'h0, 0);

    // Byte store into the top byte of that word, then sign/zero extended loads
    expect_resp(32'h0, 1'b0);
    issue(OP_SB, 32'h1001_0013, 32'h0000_0080);
    collect("sb", 2, 1'b1, 4'b0001, 1'b1, 32'h1001_0013, 32'h0000_0080, 0);
    expect_resp(32'hFFFF_FF80, 1'b0);
    issue(OP_LB, 32'h1001_0013, 32'h0);
    collect("lb", 2, 1'b1, 4'b0001, 1'b0, 32'h1001_0013, 32'h0, 0);
    expect_resp(32'h0000_0080, 1'b0);
    issue(OP_LBU, 32'h1001_0013, 32'h0);
    collect("lbu", 2, 1'b1, 4'b0001, 1'b0, 32'h1001_0013, 32'h0, 0);
    expect_resp(32'h80AD_BEEF, 1'b0);
    issue(OP_LW, 32'h1001_0010, 32'h0);
    collect("lw_merged", 2, 1'b1, 4'b1111, 1'b0, 32'h1001_0010, 32'h0, 0);

    // Halfword store and loads
    expect_resp(32'h0, 1'b0);
    issue(OP_SH, 32'h1001_0020, 32'h0000_8001);
    collect("sh", 2, 1'b1, 4'b0011, 1'b1, 32'h1001_0020, 32'h0000_8001, 0);
    expect_resp(32'hFFFF_8001, 1'b0);
    issue(OP_LH, 32'h1001_0020, 32'h0);
    collect("lh", 2, 1'b1, 4'b0011, 1'b0, 32'h1001_0020, 32'h0, 0);
    expect_resp(32'h0000_8001, 1'b0);
    issue(OP_LHU, 32'h1001_0020, 32'h0);
    collect("lhu", 2, 1'b1, 4'b0011, 1'b0, 32'h1001_0020, 32'h0, 0);

    // Error cases: one-cycle latency, no RAM cycle
    expect_resp(32'h0, 1'b1);
    issue(OP_LW, 32'h1001_0002, 32'h0);
    collect("err_lw_misal", 1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 0);
    expect_resp(32'h0, 1'b1);
    issue(OP_SH, 32'h1001_0001, 32'h0000_1234);
    collect("err_sh_misal", 1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 0);
    expect_resp(32'h0, 1'b1);
    issue(OP_LW, 32'h1001_01FE, 32'h0);
    collect("err_lw_range", 1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 0);
    expect_resp(32'h0, 1'b1);
    issue(OP_LB, 32'h1000_FFFF, 32'h0);
    collect("err_lb_below", 1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 0);
    expect_resp(32'h0, 1'b1);
    issue(OP_LBU, 32'h1001_0200, 32'h0);
    collect("err_lbu_end", 1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 0);

    // Last word and last byte of the RAM are in range
    expect_resp(32'h0, 1'b0);
    issue(OP_SW, 32'h1001_01FC, 32'h1234_5678);
    collect("sw_last", 2, 1'b1, 4'b1111, 1'b1, 32'h1001_01FC, 32'h1234_5678, 0);
    expect_resp(32'h1234_5678, 1'b0);
    issue(OP_LW, 32'h1001_01FC, 32'h0);
    collect("lw_last", 2, 1'b1, 4'b1111, 1'b0, 32'h1001_01FC, 32'h0, 0);
    expect_resp(32'h0000_0012, 1'b0);
    issue(OP_LB, 32'h1001_01FF, 32'h0);
    collect("lb_last", 2, 1'b1, 4'b0001, 1'b0, 32'h1001_01FF, 32'h0, 0);

    // Backpressure with a second request waiting behind the stalled response
    resp_ready = 1'b0;
    expect_resp(32'h80AD_BEEF, 1'b0);
    issue(OP_LW, 32'h1001_0010, 32'h0);
    req_op = OP_LBU; req_addr = 32'h1001_0013; req_wdata = 32'h0; req_valid = 1'b1;
    expect_resp(32'h0000_0080, 1'b0);
    collect("bp_lw", 2, 1'b1, 4'b1111, 1'b0, 32'h1001_0010, 32'h0, 5);
    check("bp_pending_not_taken", {31'b0, dm_ena}, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect("bp_lbu", 2, 1'b1, 4'b0001, 1'b0, 32'h1001_0013, 32'h0, 0);

    // Reset during a store's RAM cycle
    expect_resp(32'h0, 1'b0);
    issue(OP_SW, 32'h1001_0030, 32'hCAFE_F00D);
    collect("sw_prior", 2, 1'b1, 4'b1111, 1'b1, 32'h1001_0030, 32'hCAFE_F00D, 0);
    issue(OP_SW, 32'h1001_0030, 32'h1111_1111);
    #2;
    check("rstmid_ena_before", {31'b0, dm_ena}, 32'h1);
    check("rstmid_wena_before", {31'b0, dm_wena}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_ena_after", {31'b0, dm_ena}, 32'h0);
    check("rstmid_wena_after", {31'b0, dm_wena}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_resp", {31'b0, resp_valid}, 32'h0);
    check("rstmid_ready", {31'b0, req_ready}, 32'h1);
    expect_resp(32'hCAFE_F00D, 1'b0);
    issue(OP_LW, 32'h1001_0030, 32'h0);
    collect("lw_after_rst", 2, 1'b1, 4'b1111, 1'b0, 32'h1001_0030, 32'h0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
